// File: rtl/decode_ex_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_ex_pipe_pkg
//  Purpose  : Opcode map, control encodings and decode function for ID/EX.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_ex_pipe_pkg;

  localparam logic [4:0] c_OP_ADD   = 5'h01;
  localparam logic [4:0] c_OP_SUB   = 5'h02;
  localparam logic [4:0] c_OP_AND   = 5'h03;
  localparam logic [4:0] c_OP_OR    = 5'h04;
  localparam logic [4:0] c_OP_XOR   = 5'h05;
  localparam logic [4:0] c_OP_SLT   = 5'h06;
  localparam logic [4:0] c_OP_ADDI  = 5'h08;
  localparam logic [4:0] c_OP_LOAD  = 5'h09;
  localparam logic [4:0] c_OP_STORE = 5'h0A;
  localparam logic [4:0] c_OP_BEQ   = 5'h0B;
  localparam logic [4:0] c_OP_JAL   = 5'h0C;
  localparam logic [4:0] c_OP_LUI   = 5'h0D;

  localparam logic [1:0] c_IMM_S5   = 2'b00;
  localparam logic [1:0] c_IMM_S10  = 2'b01;
  localparam logic [1:0] c_IMM_S15  = 2'b10;
  localparam logic [1:0] c_IMM_U15  = 2'b11;

  localparam logic [1:0] c_RES_ALU  = 2'b00;
  localparam logic [1:0] c_RES_MEM  = 2'b01;
  localparam logic [1:0] c_RES_PC   = 2'b10;
  localparam logic [1:0] c_RES_IMM  = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_PASSB = 3'd6
  } aluCtrl_e;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       aluSrc;
    logic [1:0] resultSrc;
    aluCtrl_e   aluControl;
    logic [1:0] immSrc;
  } ctrlWord_t;

  // Undefined opcodes decode to an all-zero control word (architectural NOP).
  function automatic ctrlWord_t decodeOp(input logic [4:0] op);
    ctrlWord_t c;
    c.regWrite   = 1'b0;
    c.memWrite   = 1'b0;
    c.jump       = 1'b0;
    c.branch     = 1'b0;
    c.aluSrc     = 1'b0;
    c.resultSrc  = c_RES_ALU;
    c.aluControl = ALU_ADD;
    c.immSrc     = c_IMM_S5;
    case (op)
      c_OP_ADD: c.regWrite = 1'b1;
      c_OP_SUB: begin
        c.regWrite   = 1'b1;
        c.aluControl = ALU_SUB;
      end
      c_OP_AND: begin
        c.regWrite   = 1'b1;
        c.aluControl = ALU_AND;
      end
      c_OP_OR: begin
        c.regWrite   = 1'b1;
        c.aluControl = ALU_OR;
      end
      c_OP_XOR: begin
        c.regWrite   = 1'b1;
        c.aluControl = ALU_XOR;
      end
      c_OP_SLT: begin
        c.regWrite   = 1'b1;
        c.aluControl = ALU_SLT;
      end
      c_OP_ADDI: begin
        c.regWrite = 1'b1;
        c.aluSrc   = 1'b1;
      end
      c_OP_LOAD: begin
        c.regWrite  = 1'b1;
        c.aluSrc    = 1'b1;
        c.resultSrc = c_RES_MEM;
      end
      c_OP_STORE: begin
        c.memWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.immSrc   = c_IMM_S10;
      end
      c_OP_BEQ: begin
        c.branch     = 1'b1;
        c.aluControl = ALU_SUB;
        c.immSrc     = c_IMM_S15;
      end
      c_OP_JAL: begin
        c.regWrite  = 1'b1;
        c.jump      = 1'b1;
        c.resultSrc = c_RES_PC;
        c.immSrc    = c_IMM_S15;
      end
      c_OP_LUI: begin
        c.regWrite   = 1'b1;
        c.aluSrc     = 1'b1;
        c.resultSrc  = c_RES_IMM;
        c.aluControl = ALU_PASSB;
        c.immSrc     = c_IMM_U15;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ex_pipe_regfile_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_bypass
//  Purpose  : 2R1W register file, r0 hard-wired to zero, write-to-read bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_bypass #(
  parameter int XLEN  = 19,
  parameter int NREGS = 19
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            writeEn,
  input  logic [4:0]      writeAddr,
  input  logic [XLEN-1:0] writeData,
  input  logic [4:0]      readAddr1,
  input  logic [4:0]      readAddr2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2
);

  localparam logic [5:0] c_NREGS = 6'(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_writeOk;
  logic [4:0]      w_rdAddr [2];
  logic [XLEN-1:0] w_rdData [2];

  assign w_writeOk   = writeEn && (writeAddr != 5'd0) && ({1'b0, writeAddr} < c_NREGS);
  assign w_rdAddr[0] = readAddr1;
  assign w_rdAddr[1] = readAddr2;
  assign readData1   = w_rdData[0];
  assign readData2   = w_rdData[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_writeOk) begin
      r_regs[writeAddr] <= writeData;
    end
  end

  // Out-of-range addresses read zero even when a write to them is in flight.
  for (genvar p = 0; p < 2; p++) begin : g_read
    always_comb begin
      w_rdData[p] = '0;
      if ((w_rdAddr[p] != 5'd0) && ({1'b0, w_rdAddr[p]} < c_NREGS)) begin
        if (writeEn && (writeAddr == w_rdAddr[p])) w_rdData[p] = writeData;
        else                                       w_rdData[p] = r_regs[w_rdAddr[p]];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_ex_pipe
//  Purpose  : Decode stage with register file, load-use detection, ID/EX reg.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_ex_pipe
  import decode_ex_pipe_pkg::*;
#(
  parameter int XLEN  = 19,
  parameter int PC_W  = 15,
  parameter int NREGS = 19
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [19:0]     instr_d,
  input  logic [PC_W-1:0] pc_d,
  input  logic            valid_d,
  input  logic            flush_e,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            stall_d,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [PC_W-1:0] pc_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e
);

  ctrlWord_t       w_ctrl;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_immExt;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_loadInEx;
  logic            w_hazard;
  logic            w_bubble;

  assign w_ctrl = decodeOp(instr_d[4:0]);
  assign w_rd   = instr_d[9:5];
  assign w_rs1  = instr_d[14:10];
  assign w_rs2  = instr_d[19:15];

  always_comb begin
    w_immExt = '0;
    case (w_ctrl.immSrc)
      c_IMM_S5:  w_immExt = {{(XLEN-5){instr_d[19]}},  instr_d[19:15]};
      c_IMM_S10: w_immExt = {{(XLEN-10){instr_d[19]}}, instr_d[19:10]};
      c_IMM_S15: w_immExt = {{(XLEN-15){instr_d[19]}}, instr_d[19:5]};
      default:   w_immExt = {{(XLEN-15){1'b0}},        instr_d[19:5]};
    endcase
  end

  regfile_bypass #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .writeEn   (reg_write_w),
    .writeAddr (rd_w),
    .writeData (result_w),
    .readAddr1 (w_rs1),
    .readAddr2 (w_rs2),
    .readData1 (w_rd1),
    .readData2 (w_rd2)
  );

  // rs2 only matters when it feeds the ALU; immediate forms reuse that field.
  assign w_loadInEx = valid_e && (result_src_e == c_RES_MEM) && (rd_e != 5'd0);
  assign w_hazard   = valid_d && w_loadInEx &&
                      ((rd_e == w_rs1) || ((rd_e == w_rs2) && !w_ctrl.aluSrc));
  assign stall_d    = reset && w_hazard && !flush_e;
  assign w_bubble   = flush_e || w_hazard || !valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_e       <= 1'b0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      result_src_e  <= 2'b00;
      alu_control_e <= 3'b000;
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_ext_e     <= '0;
      pc_e          <= '0;
      rs1_e         <= 5'd0;
      rs2_e         <= 5'd0;
      rd_e          <= 5'd0;
    end else begin
      valid_e       <= !w_bubble && valid_d;
      reg_write_e   <= !w_bubble && w_ctrl.regWrite;
      mem_write_e   <= !w_bubble && w_ctrl.memWrite;
      jump_e        <= !w_bubble && w_ctrl.jump;
      branch_e      <= !w_bubble && w_ctrl.branch;
      alu_src_e     <= !w_bubble && w_ctrl.aluSrc;
      result_src_e  <= w_bubble ? 2'b00  : w_ctrl.resultSrc;
      alu_control_e <= w_bubble ? 3'b000 : w_ctrl.aluControl;
      // Data fields ride along regardless; valid_e qualifies them.
      rd1_e         <= w_rd1;
      rd2_e         <= w_rd2;
      imm_ext_e     <= w_immExt;
      pc_e          <= pc_d;
      rs1_e         <= w_rs1;
      rs2_e         <= w_rs2;
      rd_e          <= w_rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_ex_pipe
//  Purpose  : Directed and randomized checks of decode_ex_pipe vs. a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_ex_pipe;

  localparam int XLEN  = 19;
  localparam int PC_W  = 15;
  localparam int NREGS = 19;

  localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3,  OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5,  OP_SLT = 5'd6,  OP_ADDI = 5'd8, OP_LOAD = 5'd9;
  localparam logic [4:0] OP_STORE = 5'd10, OP_BEQ = 5'd11, OP_JAL = 5'd12, OP_LUI = 5'd13;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [19:0]     instr_d = '0;
  logic [PC_W-1:0] pc_d = '0;
  logic            valid_d = 1'b0, flush_e = 1'b0, reg_write_w = 1'b0;
  logic [4:0]      rd_w = '0;
  logic [XLEN-1:0] result_w = '0;
  logic            stall_d, valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_control_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e;
  logic [PC_W-1:0] pc_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;

  int checks = 0;
  int failures = 0;

  decode_ex_pipe #(.XLEN(XLEN), .PC_W(PC_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .flush_e(flush_e), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .stall_d(stall_d), .valid_e(valid_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_src_e(alu_src_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic       rw, mw, j, b, as;
    logic [1:0] rs;
    logic [2:0] alu;
    int         is;
  } dec_t;

  logic [XLEN-1:0] mRegs [32];
  logic            eValid, eRw, eMw, eJ, eB, eAs;
  logic [1:0]      eRs;
  logic [2:0]      eAlu;
  logic [XLEN-1:0] eRd1, eRd2, eImm;
  logic [PC_W-1:0] ePc;
  logic [4:0]      eRs1, eRs2, eRdA;
  logic            nValid, nRw, nMw, nJ, nB, nAs;
  logic [1:0]      nRs;
  logic [2:0]      nAlu;
  logic [XLEN-1:0] nRd1, nRd2, nImm;
  logic [PC_W-1:0] nPc;
  logic [4:0]      nRs1, nRs2, nRdA;
  logic            expStall;

  function automatic dec_t refDecode(input logic [4:0] op);
    dec_t d = '{rw: 0, mw: 0, j: 0, b: 0, as: 0, rs: 2'd0, alu: 3'd0, is: 0};
    case (op)
      OP_ADD:   d.rw = 1;
      OP_SUB:   begin d.rw = 1; d.alu = 3'd1; end
      OP_AND:   begin d.rw = 1; d.alu = 3'd2; end
      OP_OR:    begin d.rw = 1; d.alu = 3'd3; end
      OP_XOR:   begin d.rw = 1; d.alu = 3'd4; end
      OP_SLT:   begin d.rw = 1; d.alu = 3'd5; end
      OP_ADDI:  begin d.rw = 1; d.as = 1; end
      OP_LOAD:  begin d.rw = 1; d.as = 1; d.rs = 2'd1; end
      OP_STORE: begin d.mw = 1; d.as = 1; d.is = 1; end
      OP_BEQ:   begin d.b = 1; d.alu = 3'd1; d.is = 2; end
      OP_JAL:   begin d.rw = 1; d.j = 1; d.rs = 2'd2; d.is = 2; end
      OP_LUI:   begin d.rw = 1; d.as = 1; d.rs = 2'd3; d.alu = 3'd6; d.is = 3; end
      default: ;
    endcase
    return d;
  endfunction

  // Field value as an integer, sign-corrected arithmetically, then wrapped to XLEN.
  function automatic logic [XLEN-1:0] refImm(input logic [19:0] ins, input int is);
    int lo, w, v;
    lo = (is == 0) ? 15 : (is == 1) ? 10 : 5;
    w  = 20 - lo;
    v  = int'(ins >> lo) % (1 << w);
    if (is != 3 && v >= (1 << (w - 1))) v = v - (1 << w);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] refRead(input int a);
    if (a == 0 || a >= NREGS) return '0;
    if (reg_write_w && int'(rd_w) == a) return result_w;
    return mRegs[a];
  endfunction

  function automatic logic [19:0] mkInstr(input logic [4:0] op, input int rd, input int rs1, input int rs2);
    return {5'(rs2), 5'(rs1), 5'(rd), op};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    {eValid, eRw, eMw, eJ, eB, eAs, eRs, eAlu} = '0;
    {eRd1, eRd2, eImm, ePc, eRs1, eRs2, eRdA} = '0;
  endtask

  task automatic predict();
    dec_t d;
    logic haz, bub;
    d   = refDecode(instr_d[4:0]);
    haz = valid_d && eValid && eRs == 2'd1 && eRdA != 0 &&
          (eRdA == instr_d[14:10] || (eRdA == instr_d[19:15] && !d.as));
    expStall = haz && !flush_e;
    bub = flush_e || haz || !valid_d;
    nValid = !bub;
    nRw = !bub && d.rw; nMw = !bub && d.mw; nJ = !bub && d.j; nB = !bub && d.b; nAs = !bub && d.as;
    nRs  = bub ? 2'd0 : d.rs;
    nAlu = bub ? 3'd0 : d.alu;
    nRd1 = refRead(int'(instr_d[14:10]));
    nRd2 = refRead(int'(instr_d[19:15]));
    nImm = refImm(instr_d, d.is);
    nPc  = pc_d;
    nRs1 = instr_d[14:10]; nRs2 = instr_d[19:15]; nRdA = instr_d[9:5];
  endtask

  task automatic tick();
    @(posedge clk);
    {eValid, eRw, eMw, eJ, eB, eAs, eRs, eAlu} = {nValid, nRw, nMw, nJ, nB, nAs, nRs, nAlu};
    {eRd1, eRd2, eImm, ePc, eRs1, eRs2, eRdA} = {nRd1, nRd2, nImm, nPc, nRs1, nRs2, nRdA};
    if (reg_write_w && rd_w != 0 && int'(rd_w) < NREGS) mRegs[rd_w] = result_w;
    #1;
  endtask

  task automatic drive(input logic [19:0] ins, input logic vd, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wd);
    @(negedge clk);
    instr_d = ins; valid_d = vd; flush_e = fl;
    reg_write_w = we; rd_w = wa; result_w = wd;
    pc_d = PC_W'($urandom_range(0, 32767));
    #1;
    predict();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    modelReset();
    #2;
    checks++;
    if ({stall_d, valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
         result_src_e, alu_control_e, rd1_e, rd2_e, imm_ext_e, pc_e, rs1_e, rs2_e, rd_e} !== '0) begin
      failures++; $display("FAIL reset_init: outputs not all zero, valid_e=%b rd_e=%0d", valid_e, rd_e);
    end
    @(posedge clk); #1; reset = 1'b1;
    drive(mkInstr(5'd0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 5'd5, 19'h00055); tick();
    drive(mkInstr(OP_LOAD, 4, 1, 0), 1'b1, 1'b0, 1'b0, 5'd0, '0); tick();
    drive(mkInstr(OP_ADD, 6, 4, 2), 1'b1, 1'b0, 1'b0, 5'd0, '0);
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL reset_prestall: stall_d=%b required 1", stall_d); end
    reset = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({stall_d, valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
         result_src_e, alu_control_e, rd1_e, rd2_e, imm_ext_e, pc_e, rs1_e, rs2_e, rd_e} !== '0) begin
      failures++; $display("FAIL reset_async: stall_d=%b valid_e=%b rd_e=%0d required all zero", stall_d, valid_e, rd_e);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(mkInstr(OP_ADD, 7, 5, 0), 1'b1, 1'b0, 1'b0, 5'd0, '0); tick();
    checks++;
    if (rd1_e !== '0 || valid_e !== 1'b1) begin
      failures++; $display("FAIL reset_r5: rd1_e=%h valid_e=%b required 0 and 1", rd1_e, valid_e);
    end
  endtask

  task automatic test_bypass();
    drive(mkInstr(OP_ADD, 7, 3, 0), 1'b1, 1'b0, 1'b1, 5'd3, 19'h01234); tick();
    checks++;
    if (rd1_e !== 19'h01234) begin failures++; $display("FAIL bypass: rd1_e=%h required 01234", rd1_e); end
    drive(mkInstr(OP_SUB, 7, 0, 3), 1'b1, 1'b0, 1'b0, 5'd0, '0); tick();
    checks++;
    if (rd2_e !== 19'h01234) begin failures++; $display("FAIL stored_read: rd2_e=%h required 01234", rd2_e); end
  endtask

  task automatic test_zero_reg();
    drive(mkInstr(5'd0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 5'd0, 19'h7FFFF); tick();
    drive(mkInstr(OP_ADD, 1, 0, 20), 1'b1, 1'b0, 1'b1, 5'd20, 19'h2AAAA); tick();
    drive(mkInstr(OP_ADD, 1, 0, 20), 1'b1, 1'b0, 1'b1, 5'd0, 19'h7FFFF); tick();
    checks++;
    if (rd1_e !== '0) begin failures++; $display("FAIL zero_reg: rd1_e=%h required 0", rd1_e); end
    checks++;
    if (rd2_e !== '0) begin failures++; $display("FAIL out_of_range: rd2_e=%h required 0", rd2_e); end
  endtask

  task automatic test_load_use();
    drive(mkInstr(OP_LOAD, 4, 1, 0), 1'b1, 1'b0, 1'b0, 5'd0, '0); tick();
    drive(mkInstr(OP_ADD, 6, 2, 4), 1'b1, 1'b0, 1'b0, 5'd0, '0);
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL lu_stall: stall_d=%b required 1", stall_d); end
    tick();
    checks++;
    if (valid_e !== 1'b0 || reg_write_e !== 1'b0) begin
      failures++; $display("FAIL lu_bubble: valid_e=%b reg_write_e=%b required 0 0", valid_e, reg_write_e);
    end
    drive(mkInstr(OP_ADD, 6, 2, 4), 1'b1, 1'b0, 1'b0, 5'd0, '0);
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL lu_release: stall_d=%b required 0", stall_d); end
    tick();
    checks++;
    if (valid_e !== 1'b1 || rs2_e !== 5'd4) begin
      failures++; $display("FAIL lu_issue: valid_e=%b rs2_e=%0d required 1 4", valid_e, rs2_e);
    end
    drive(mkInstr(OP_LOAD, 4, 1, 0), 1'b1, 1'b0, 1'b0, 5'd0, '0); tick();
    drive(mkInstr(OP_ADDI, 6, 2, 4), 1'b1, 1'b0, 1'b0, 5'd0, '0);
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL lu_imm_rs2: stall_d=%b required 0", stall_d); end
    tick();
  endtask

  task automatic test_flush();
    drive(mkInstr(OP_LOAD, 4, 1, 0), 1'b1, 1'b0, 1'b0, 5'd0, '0); tick();
    drive(mkInstr(OP_ADD, 6, 4, 2), 1'b1, 1'b1, 1'b0, 5'd0, '0);
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL flush_stall: stall_d=%b required 0", stall_d); end
    tick();
    checks++;
    if (valid_e !== 1'b0) begin failures++; $display("FAIL flush_bubble: valid_e=%b required 0", valid_e); end
  endtask

  task automatic test_imm();
    logic [XLEN-1:0] req [4] = '{19'h7C000, 19'h04000, 19'h7FFF0, 19'h7FE00};
    logic [19:0] ins [4];
    ins[0] = {15'h4000, OP_BEQ};
    ins[1] = {15'h4000, OP_LUI};
    ins[2] = {5'h10, 10'h000, OP_ADDI};
    ins[3] = {10'h200, 5'd0, OP_STORE};
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], 1'b1, 1'b0, 1'b0, 5'd0, '0); tick();
      checks++;
      if (imm_ext_e !== req[i]) begin
        failures++; $display("FAIL imm_%0d: imm_ext_e=%h required %h", i, imm_ext_e, req[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] ins;
    logic held = 1'b0;
    ins = '0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        int op, sm;
        op = ($urandom_range(0, 15) == 0) ? 31 : int'($urandom_range(0, 14));
        sm = ($urandom_range(0, 4) == 0) ? 31 : 7;
        ins = mkInstr(5'(op), int'($urandom_range(0, sm)), int'($urandom_range(0, sm)),
                      int'($urandom_range(0, sm)));
      end
      drive(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7)), XLEN'($urandom));
      checks++;
      if (stall_d !== expStall) begin
        failures++; $display("FAIL rnd_stall[%0d]: stall_d=%b required %b", n, stall_d, expStall);
      end
      held = expStall;
      tick();
      checks++;
      if ({valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, result_src_e, alu_control_e}
          !== {eValid, eRw, eMw, eJ, eB, eAs, eRs, eAlu}) begin
        failures++;
        $display("FAIL rnd_ctrl[%0d]: got %b required %b", n,
                 {valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, result_src_e, alu_control_e},
                 {eValid, eRw, eMw, eJ, eB, eAs, eRs, eAlu});
      end
      if (eValid) begin
        checks++;
        if ({rd1_e, rd2_e, imm_ext_e, pc_e, rs1_e, rs2_e, rd_e} !== {eRd1, eRd2, eImm, ePc, eRs1, eRs2, eRdA}) begin
          failures++;
          $display("FAIL rnd_data[%0d]: rd1=%h rd2=%h imm=%h pc=%h regs=%0d/%0d/%0d required %h %h %h %h %0d/%0d/%0d",
                   n, rd1_e, rd2_e, imm_ext_e, pc_e, rs1_e, rs2_e, rd_e,
                   eRd1, eRd2, eImm, ePc, eRs1, eRs2, eRdA);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_load_use();
    test_flush();
    test_imm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/decode_ex_pipe.md
DECODE_EX_PIPE -- requirements
Module: decode_ex_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XLEN, 19, register/data width.
- PC_W, 15, program-counter width.
- NREGS, 19, architectural register count (max 32); address field is 5 bits.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low reset.
- instr_d, in, 20, instruction: [4:0] opcode, [9:5] rd, [14:10] rs1, [19:15] rs2, [19:5] immediate source.
- pc_d, in, PC_W, decode-stage PC.
- valid_d, in, 1, instr_d holds a real instruction.
- flush_e, in, 1, taken branch/jump from EX.
- reg_write_w, in, 1, writeback enable.
- rd_w, in, 5, writeback address.
- result_w, in, XLEN, writeback data.
- stall_d, out, 1, hold IF/ID (load-use).
- valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, out, 1 each, EX control.
- result_src_e, out, 2, result select (01 = load).
- alu_control_e, out, 3, ALU operation.
- rd1_e, rd2_e, imm_ext_e, out, XLEN each, operands and immediate.
- pc_e, out, PC_W, EX-stage PC.
- rs1_e, rs2_e, rd_e, out, 5 each, source and destination addresses for forwarding.

Function
REQ-003 The block SHALL decode opcode instr_d[4:0] into RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0] and ImmSrc[1:0], combinationally.
REQ-004 The block SHALL sign-extend instr_d[19:5] to XLEN per ImmSrc:
- 00: bits [19:15].
- 01: bits [19:10].
- 10: bits [19:5].
- 11: zero-extend [19:5].
REQ-005 The register file SHALL have NREGS entries with two asynchronous reads (rs1, rs2) and one synchronous write on the rising clk edge when reg_write_w=1.
REQ-006 Register 0 SHALL read as zero; writes to it SHALL be ignored.
REQ-007 Writes with rd_w >= NREGS SHALL be ignored, and reads of addresses >= NREGS SHALL return zero.
REQ-008 The register file SHALL bypass write-to-read in the same cycle: a read address equal to rd_w with reg_write_w=1 and rd_w!=0 SHALL return result_w.
REQ-009 All _e outputs SHALL come from the ID/EX register, giving one-cycle latency from decode to EX.
REQ-010 A load-use hazard SHALL be flagged when all of the following hold:
- valid_e=1;
- result_src_e=01;
- rd_e!=0;
- rd_e equals instr_d[14:10], or rd_e equals instr_d[19:15] and the decoded ALUSrc=0;
- valid_d=1.
REQ-011 On a load-use hazard, stall_d SHALL be 1 in the same cycle (combinational), and the next edge SHALL load a bubble into ID/EX.
REQ-012 A bubble SHALL set valid_e=0 and clear all control outputs to 0; data fields are don't-care.
REQ-013 flush_e=1 SHALL load a bubble on the next edge.
REQ-014 When flush_e=1, stall_d SHALL be 0, regardless of any hazard (flush has priority).
REQ-015 With valid_d=0, the block SHALL load a bubble and SHALL NOT raise stall_d.
REQ-016 Otherwise, each edge SHALL capture the decoded fields, with valid_e=valid_d.
REQ-017 A stall SHALL last exactly one cycle per load: after the bubble, valid_e=0, so the hazard clears.

Reset
REQ-018 When reset=0, the block SHALL asynchronously clear all ID/EX fields, all register-file entries, valid_e and stall_d to 0.
REQ-019 Release SHALL be synchronous to clk.
REQ-020 A reset asserted mid-stall SHALL abort the stall.

Structure
REQ-021 A shared package SHALL hold:
- opcode constants;
- ImmSrc and ResultSrc encodings;
- the ALUControl enum;
- the control-word struct;
- the decode function.
REQ-022 The register file SHALL be one sub-module, regfile_bypass, parametrised by XLEN and NREGS.
REQ-023 Hazard detection and the pipeline register SHALL live in decode_ex_pipe.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset: assert reset=0 mid-run -> every _e output and stall_d become 0 immediately, and a later read of r5 returns 0.
- Bypass: write r3=0x1234 with instr_d reading rs1=3 in the same cycle -> rd1_e=0x1234 next cycle.
- Zero register: write r0=0x7FFFF -> a later read of r0 returns 0.
- Load-use: load to r4 in EX, then an instr_d using rs2=4 with ALUSrc=0 -> stall_d=1 for one cycle, valid_e=0 next cycle, then the instruction issues with valid_e=1.
- Flush priority: flush_e=1 during a load-use hazard -> stall_d=0 and valid_e=0 next cycle.
- Immediate extension: instr_d[19:5]=0x4000 with ImmSrc=10 -> imm_ext_e=0x7C000 (XLEN=19).
